// File: rtl/xmsched_pkg.sv
// Shared state encodings and block-geometry constants for the SHA-256 schedule sequencer.
package xmsched_pkg;
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RUN    = 3'd1,
    ST_LOAD   = 3'd2,
    ST_GAP    = 3'd3,
    ST_EXPAND = 3'd4
  } state_t;

  localparam int LOAD_WORDS = 16;
  localparam int ROUNDS     = 64;
  localparam int GAP_CYCLES = 1;
endpackage

// File: rtl/xmsched_fifo.sv
// Synchronous word FIFO with occupancy count; DEPTH must be a power of two so pointers wrap for free.
module xmsched_fifo #(
  parameter  int DATA_W = 32,
  parameter  int DEPTH  = 16,
  localparam int AW     = $clog2(DEPTH),
  localparam int CW     = AW + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clear,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata,
  output logic [CW-1:0]     o_count
);
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wptr, r_rptr;
  logic [CW-1:0]     r_count;

  always_ff @(posedge clk)
    if (i_push) r_mem[r_wptr] <= i_wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_clear) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + AW'(1);
      if (i_pop)  r_rptr <= r_rptr + AW'(1);
      r_count <= r_count + CW'(i_push) - CW'(i_pop);
    end
  end

  assign o_rdata = r_mem[r_rptr];
  assign o_count = r_count;
endmodule

// File: rtl/xmsched_ctrl.sv
// Sequencer for the SHA-256 message-schedule unit: buffers words, feeds 16, streams W[0..63].
// Optional XMSCHED_PERF_EN adds blk_cnt / stall_cnt performance counters.
module xmsched_ctrl
  import xmsched_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int BUF_DEPTH   = 16,
  parameter int SCHED_DELAY = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] w_data,
  output logic              w_valid,
  output logic [5:0]        w_idx,
  output logic              w_last,
  output logic              busy,
  output logic              err,
  output logic              sched_run,
  output logic [7:0]        sched_delay0,
  output logic [DATA_W-1:0] sched_in0,
  input  logic              sched_done,
`ifdef XMSCHED_PERF_EN
  output logic [31:0]       blk_cnt,
  output logic [31:0]       stall_cnt,
`endif
  input  logic [DATA_W-1:0] sched_out0
);
  localparam int CW = $clog2(BUF_DEPTH) + 1;

  state_t            r_state, w_next;
  logic [5:0]        r_idx;
  logic              r_err;
  logic [CW-1:0]     w_count;
  logic [DATA_W-1:0] w_head;
  logic              w_pop, w_push, w_room, w_have_blk;

  assign w_pop      = (r_state == ST_LOAD);
  assign w_room     = (w_count < CW'(BUF_DEPTH)) || w_pop;
  assign w_push     = in_valid && w_room && !clear;
  assign w_have_blk = (w_count >= CW'(LOAD_WORDS));

  xmsched_fifo #(.DATA_W(DATA_W), .DEPTH(BUF_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clear (clear),
    .i_push  (w_push),
    .i_pop   (w_pop && !clear),
    .i_wdata (in_data),
    .o_rdata (w_head),
    .o_count (w_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     r_state <= ST_IDLE;
    else if (clear) r_state <= ST_IDLE;
    else            r_state <= w_next;
  end

  // The last EXPAND cycle may chain straight into RUN so blocks can repeat every 66 cycles.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_have_blk) w_next = ST_RUN;
      ST_RUN:    w_next = ST_LOAD;
      ST_LOAD:   if (r_idx == 6'(LOAD_WORDS - 1)) w_next = ST_GAP;
      ST_GAP:    w_next = ST_EXPAND;
      ST_EXPAND: if (r_idx == 6'(ROUNDS - 1)) w_next = w_have_blk ? ST_RUN : ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    sched_run = 1'b0;
    w_valid   = 1'b0;
    w_data    = '0;
    sched_in0 = '0;
    w_last    = 1'b0;
    case (r_state)
      ST_RUN:  sched_run = 1'b1;
      ST_LOAD: begin
        w_valid   = 1'b1;
        w_data    = w_head;
        sched_in0 = w_head;
      end
      ST_EXPAND: begin
        w_valid = 1'b1;
        w_data  = sched_out0;
        w_last  = (r_idx == 6'(ROUNDS - 1));
      end
      default: ;
    endcase
  end

  // Index runs 0..15 in LOAD, holds 16 across GAP, then 16..63 and wraps to 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx <= '0;
      r_err <= 1'b0;
    end else if (clear) begin
      r_idx <= '0;
      r_err <= 1'b0;
    end else begin
      if (w_valid) r_idx <= r_idx + 6'd1;
      if (r_state == ST_GAP && !sched_done) r_err <= 1'b1;
    end
  end

  assign w_idx        = r_idx;
  assign err          = r_err;
  assign busy         = (r_state != ST_IDLE);
  assign in_ready     = rst_n && w_room;
  assign sched_delay0 = 8'(SCHED_DELAY);

`ifdef XMSCHED_PERF_EN
  logic [31:0] r_blk_cnt, r_stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_blk_cnt   <= '0;
      r_stall_cnt <= '0;
    end else if (clear) begin
      r_blk_cnt   <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_last) r_blk_cnt <= r_blk_cnt + 32'd1;
      if (r_state == ST_IDLE && w_count != '0 && !w_have_blk)
        r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign blk_cnt   = r_blk_cnt;
  assign stall_cnt = r_stall_cnt;
`endif
endmodule

// File: tb/tb_xmsched_ctrl.sv
// Randomized bench for xmsched_ctrl with a behavioural SHA-256 schedule unit and stream scoreboard.
module tb_xmsched_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] w_data;
  logic        w_valid;
  logic [5:0]  w_idx;
  logic        w_last;
  logic        busy;
  logic        err;
  logic        sched_run;
  logic [7:0]  sched_delay0;
  logic [31:0] sched_in0;
  logic        sched_done = 1'b0;
  logic [31:0] sched_out0 = '0;
`ifdef XMSCHED_PERF_EN
  logic [31:0] blk_cnt, stall_cnt;
`endif

  xmsched_ctrl #(.DATA_W(32), .BUF_DEPTH(32), .SCHED_DELAY(0)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .w_data(w_data), .w_valid(w_valid), .w_idx(w_idx), .w_last(w_last),
    .busy(busy), .err(err), .sched_run(sched_run), .sched_delay0(sched_delay0),
    .sched_in0(sched_in0), .sched_done(sched_done),
`ifdef XMSCHED_PERF_EN
    .blk_cnt(blk_cnt), .stall_cnt(stall_cnt),
`endif
    .sched_out0(sched_out0)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    int          idx;
    logic [31:0] d;
    logic        last;
  } wrec_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          err_cyc = -1;
  int          last_l0 = 0;
  wrec_t       wq[$];
  int          runq[$];
  logic [31:0] mq[$];
  logic [31:0] gotw[64];

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Reference SHA-256 message expansion.
  task automatic expand(input logic [31:0] m[16], output logic [31:0] w[64]);
    logic [31:0] s0, s1;
    for (int t = 0; t < 16; t++) w[t] = m[t];
    for (int t = 16; t < 64; t++) begin
      s0 = ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3);
      s1 = ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10);
      w[t] = s1 + w[t-7] + s0 + w[t-16];
    end
  endtask

  // Behavioural schedule unit: captures 16 words after run, done at +17, W16.. from +18.
  bit          done_en = 1'b1;
  int          uc = -1;
  logic [31:0] uin[16];
  logic [31:0] uw[64];
  always @(posedge clk) begin
    #1;
    if (!rst_n) uc = -1;
    else if (sched_run) uc = 0;
    else if (uc >= 0 && uc < 70) uc++;
    if (uc >= 1 && uc <= 16) uin[uc-1] = sched_in0;
    if (uc == 16) expand(uin, uw);
    sched_done = done_en && (uc == 17);
    sched_out0 = (uc >= 18 && uc <= 65) ? uw[uc-2] : 32'h0;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    wrec_t r;
    if (rst_n) begin
      if (w_valid || w_last) begin
        r.cyc = cyc; r.idx = int'(w_idx); r.d = w_data; r.last = w_last;
        wq.push_back(r);
      end
      if (sched_run) runq.push_back(cyc);
      if (err && err_cyc < 0) err_cyc = cyc;
    end
  end

  task automatic push_word(input logic [31:0] d, output int acc);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && n < 200) begin @(negedge clk); n++; end
    acc = cyc;
    if (n >= 200) begin
      checks++; errors++;
      $display("FAIL push_timeout: in_ready low for %0d cycles, need high", n);
    end else mq.push_back(d);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic pulse_clear(input bit with_push);
    @(negedge clk);
    clear = 1'b1;
    in_valid = with_push;
    in_data = $urandom;
    @(posedge clk); #1;
    clear = 1'b0;
    in_valid = 1'b0;
  endtask

  // Pops one block from the scoreboard and checks index, data, timing and w_last of all 64 words.
  task automatic verify_block(input string nm);
    int n = 0;
    int l0, ecyc;
    logic [31:0] m[16];
    logic [31:0] w[64];
    wrec_t r;
    while ((wq.size() < 64 || runq.size() == 0) && n < 400) begin @(posedge clk); n++; end
    checks++;
    if (n >= 400 || mq.size() < 16) begin
      errors++;
      $display("FAIL %s_timeout: got %0d words %0d runs, need 64 words 1 run", nm, wq.size(), runq.size());
      return;
    end
    l0 = runq.pop_front();
    last_l0 = l0;
    for (int i = 0; i < 16; i++) m[i] = mq.pop_front();
    expand(m, w);
    for (int i = 0; i < 64; i++) begin
      r = wq.pop_front();
      gotw[i] = r.d;
      ecyc = l0 + 1 + i + ((i >= 16) ? 1 : 0);
      checks++;
      if (r.idx !== i || r.d !== w[i] || r.cyc !== ecyc || r.last !== (i == 63)) begin
        errors++;
        $display("FAIL %s_w%0d: idx=%0d data=%h cyc=%0d last=%b, need idx=%0d data=%h cyc=%0d last=%b",
                 nm, i, r.idx, r.d, r.cyc, r.last, i, w[i], ecyc, (i == 63));
      end
    end
  endtask

  task automatic wait_run(output int l0);
    int n = 0;
    while (runq.size() == 0 && n < 200) begin @(posedge clk); n++; end
    checks++;
    if (runq.size() == 0) begin
      errors++; l0 = cyc;
      $display("FAIL wait_run: no sched_run within 200 cycles, need one");
    end else l0 = runq[0];
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({in_ready, w_valid, busy, err, sched_run, w_last} !== 6'b0 || w_data !== 0 || w_idx !== 0 ||
        sched_in0 !== 0 || sched_delay0 !== 8'd0) begin
      errors++;
      $display("FAIL reset_outputs: rdy=%b wv=%b busy=%b err=%b run=%b idx=%0d data=%h, need all 0",
               in_ready, w_valid, busy, err, sched_run, w_idx, w_data);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: in_ready=%b busy=%b, need 1 0", in_ready, busy);
    end
  endtask

  task automatic test_abc();
    logic [31:0] msg[16];
    int acc;
    for (int i = 0; i < 16; i++) msg[i] = 32'h0;
    msg[0] = 32'h61626380;
    msg[15] = 32'h00000018;
    for (int i = 0; i < 16; i++) push_word(msg[i], acc);
    verify_block("abc");
    checks++;
    if (gotw[16] !== 32'h61626380 || gotw[17] !== 32'h000F0000 || gotw[63] !== 32'h12B1EDEB || err !== 1'b0) begin
      errors++;
      $display("FAIL abc_known: W16=%h W17=%h W63=%h err=%b, need 61626380 000f0000 12b1edeb 0",
               gotw[16], gotw[17], gotw[63], err);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] p[32];
    int acc[32];
    int l0a;
    for (int i = 0; i < 32; i++) begin
      p[i] = $urandom;
      push_word(p[i], acc[i]);
    end
    checks++;
    if (acc[31] - acc[0] !== 31) begin
      errors++;
      $display("FAIL b2b_ready: 32 pushes spanned %0d cycles, need 31", acc[31] - acc[0]);
    end
    verify_block("b2b_blk0");
    l0a = last_l0;
    verify_block("b2b_blk1");
    checks++;
    if (last_l0 - l0a !== 66 || gotw[0] !== p[16]) begin
      errors++;
      $display("FAIL b2b_period: run gap=%0d W0=%h, need 66 %h", last_l0 - l0a, gotw[0], p[16]);
    end
  endtask

  task automatic test_idle15();
    int bad = 0;
    int acc;
    for (int i = 0; i < 15; i++) push_word($urandom, acc);
    repeat (100) begin
      @(negedge clk);
      if (busy !== 1'b0 || sched_run !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0 || runq.size() !== 0) begin
      errors++;
      $display("FAIL idle15: %0d busy/run cycles, %0d runs, need 0 0", bad, runq.size());
    end
    push_word($urandom, acc);
    verify_block("idle15_blk");
    checks++;
    if (last_l0 !== acc + 2) begin
      errors++;
      $display("FAIL idle15_run_cycle: run at %0d, need %0d", last_l0, acc + 2);
    end
  endtask

  task automatic test_clear();
    int l0, acc;
    for (int i = 0; i < 16; i++) push_word($urandom, acc);
    wait_run(l0);
    while (cyc < l0 + 29) @(negedge clk);
    pulse_clear(1'b1);
    @(negedge clk);
    checks++;
    if (w_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || sched_run !== 1'b0 || w_last !== 1'b0) begin
      errors++;
      $display("FAIL clear_next: wv=%b busy=%b rdy=%b run=%b last=%b, need 0 0 1 0 0",
               w_valid, busy, in_ready, sched_run, w_last);
    end
    wq.delete(); runq.delete(); mq.delete();
    repeat (20) @(negedge clk);
    checks++;
    if (runq.size() !== 0 || wq.size() !== 0) begin
      errors++;
      $display("FAIL clear_quiet: runs=%0d words=%0d after clear, need 0 0", runq.size(), wq.size());
    end
    for (int i = 0; i < 16; i++) push_word($urandom, acc);
    verify_block("clear_fresh");
  endtask

  task automatic test_reset_mid();
    int l0, acc;
    for (int i = 0; i < 16; i++) push_word($urandom, acc);
    wait_run(l0);
    while (cyc < l0 + 40) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({w_valid, busy, in_ready, sched_run, w_last, err} !== 6'b0 || w_data !== 0 || w_idx !== 0 || sched_in0 !== 0) begin
      errors++;
      $display("FAIL reset_mid_async: wv=%b busy=%b rdy=%b idx=%0d data=%h, need all 0",
               w_valid, busy, in_ready, w_idx, w_data);
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    wq.delete(); runq.delete(); mq.delete();
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_release: in_ready=%b busy=%b, need 1 0", in_ready, busy);
    end
    repeat (40) @(negedge clk);
    checks++;
    if (wq.size() !== 0 || runq.size() !== 0) begin
      errors++;
      $display("FAIL reset_mid_abandon: words=%0d runs=%0d, need 0 0", wq.size(), runq.size());
    end
  endtask

  task automatic test_err();
    int acc;
    done_en = 1'b0;
    err_cyc = -1;
    for (int i = 0; i < 16; i++) push_word($urandom, acc);
    verify_block("err_blk0");
    checks++;
    if (err !== 1'b1 || err_cyc !== last_l0 + 18) begin
      errors++;
      $display("FAIL err_set: err=%b first seen %0d, need 1 at %0d", err, err_cyc, last_l0 + 18);
    end
    for (int i = 0; i < 16; i++) push_word($urandom, acc);
    verify_block("err_blk1");
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL err_sticky: err=%b, need 1", err);
    end
    pulse_clear(1'b0);
    @(negedge clk);
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL err_clear: err=%b, need 0", err);
    end
    done_en = 1'b1;
  endtask

  initial begin
    test_reset();
    test_abc();
    test_back_to_back();
    test_idle15();
    test_clear();
    test_reset_mid();
    test_err();
    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
